// File: rtl/histogram_cdf_builder.sv
// histogram_cdf_builder: streams a packed 4-bin-per-word histogram from scratch memory and writes back its running CDF
//
// Ports:
//   clock_i          - single clock, all state updates on posedge
//   reset_i          - asynchronous active-high reset
//   start_i          - one-cycle pulse that begins a build (ignored while busy)
//   read_base_i      - address of histogram word 0, sampled on start
//   write_base_i     - address of CDF word 0, sampled on start
//   read_enable_o    - scratch read strobe
//   read_address_o   - read_base + k
//   rdata_i          - read data, valid one cycle after read_enable_o
//   write_enable_o   - scratch write strobe
//   write_address_o  - write_base + k
//   wdata_o          - CDF word, lane j at [32j+31:32j], lane 0 lowest bin
//   busy_o           - high from the cycle after start through the done cycle
//   done_o           - one-cycle pulse after the last write
//   total_count_o    - sum of all bins, held until the next start
//   cdf_min_o        - first non-zero CDF value in bin order, 0 if empty
module histogram_cdf_builder #(
    parameter int NUM_WORDS  = 64,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] read_base_i,
    input  logic [ADDR_WIDTH-1:0] write_base_i,
    output logic                  read_enable_o,
    output logic [ADDR_WIDTH-1:0] read_address_o,
    input  logic [127:0]          rdata_i,
    output logic                  write_enable_o,
    output logic [ADDR_WIDTH-1:0] write_address_o,
    output logic [127:0]          wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           total_count_o,
    output logic [31:0]           cdf_min_o
);
    localparam int CW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] wbase_q, wbase_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [127:0]          wdata_q, wdata_d;
    logic [31:0]           sum_q, sum_d;
    logic [31:0]           total_q, total_d;
    logic [31:0]           cdf_min_q, cdf_min_d;
    logic                  found_q, found_d;
    logic                  done_q, done_d;

    logic [31:0] c0, c1, c2, c3, lane_first;
    logic        lane_nz;

    assign c0 = sum_q + rdata_i[31:0];
    assign c1 = c0 + rdata_i[63:32];
    assign c2 = c1 + rdata_i[95:64];
    assign c3 = c2 + rdata_i[127:96];
    assign lane_nz = (c0 | c1 | c2 | c3) != 32'd0;
    assign lane_first = c0 != 32'd0 ? c0 : c1 != 32'd0 ? c1 : c2 != 32'd0 ? c2 : c3;

    always_comb begin
        state_d   = state_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        rd_cnt_d  = rd_cnt_q;
        wbase_d   = wbase_q;
        wr_addr_d = wr_addr_q;
        wdata_d   = wdata_q;
        sum_d     = sum_q;
        total_d   = total_q;
        cdf_min_d = cdf_min_q;
        found_d   = found_q;
        done_d    = 1'b0;
        rvalid_d  = rd_en_q;
        wr_en_d   = rvalid_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d   = RUN;
                rd_en_d   = 1'b1;
                rd_addr_d = read_base_i;
                rd_cnt_d  = '0;
                wbase_d   = write_base_i;
                sum_d     = '0;
                total_d   = '0;
                cdf_min_d = '0;
                found_d   = 1'b0;
            end
            RUN: if (rd_cnt_q == LAST) begin
                rd_en_d = 1'b0;
                state_d = DRAIN;
            end else begin
                rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                rd_cnt_d  = rd_cnt_q + CW'(1);
            end
            // The final write is the only write cycle with no read data behind it.
            DRAIN: if (wr_en_q && !rvalid_q) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (rvalid_q) begin
            wdata_d   = {c3, c2, c1, c0};
            sum_d     = c3;
            wr_addr_d = wr_en_q ? wr_addr_q + ADDR_WIDTH'(1) : wbase_q;
            // Reads have stopped, so this returned word is the last one.
            total_d   = rd_en_q ? total_q : c3;
            if (!found_q && lane_nz) begin
                cdf_min_d = lane_first;
                found_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_cnt_q  <= '0;
            rvalid_q  <= 1'b0;
            wbase_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
            sum_q     <= '0;
            total_q   <= '0;
            cdf_min_q <= '0;
            found_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_cnt_q  <= rd_cnt_d;
            rvalid_q  <= rvalid_d;
            wbase_q   <= wbase_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wdata_q   <= wdata_d;
            sum_q     <= sum_d;
            total_q   <= total_d;
            cdf_min_q <= cdf_min_d;
            found_q   <= found_d;
            done_q    <= done_d;
        end
    end

    assign read_enable_o   = rd_en_q;
    assign read_address_o  = rd_addr_q;
    assign write_enable_o  = wr_en_q;
    assign write_address_o = wr_addr_q;
    assign wdata_o         = wdata_q;
    assign busy_o          = state_q != IDLE;
    assign done_o          = done_q;
    assign total_count_o   = total_q;
    assign cdf_min_o       = cdf_min_q;
endmodule
